bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter and sequencer for the shared 32-channel × 20-bit select path. It accepts up to 32 level requests and grants exactly one at a time. It drives the 5-bit select for the channel mux/demux and the matching one-hot decode, and registers the selected 20-bit word onto a shared output. Fairness is enforced by a rotating priority pointer and an optional per-grant tenure limit.

## Interface
Parameters:
- HOLD_MAX, 16, maximum consecutive cycles one requester may hold the grant; legal range 2..256.

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  [31:0]  level request per channel; bit i = channel i
- in_data  input  [31:0][19:0]  per-channel 20-bit source word
- gnt  output  [31:0]  one-hot grant; all-zero when idle
- gnt_idx  output  [4:0]  binary index of the granted channel; 0 when idle
- gnt_valid  output  1  high while any grant is active
- out_data  output  [19:0]  registered word from the granted channel
- out_valid  output  1  out_data holds a word sampled under a valid grant

## Operation
- State machine: IDLE and GRANT.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick the winner: the first set req bit at or above ptr, searching upward and wrapping 31→0. Enter GRANT.
- GRANT: the current owner is gnt_idx. The grant is released at an edge if either condition holds:
  - req[gnt_idx] is low;
  - tenure expires: tcnt == HOLD_MAX-1 (only when ARB_TENURE_LIMIT_EN is defined).
- On release:
  - ptr ← gnt_idx+1, mod 32.
  - If any req bit is set, the winner is chosen from the new ptr in the same edge and the block stays in GRANT. There are no idle bubbles.
  - Otherwise the block goes to IDLE.
- If the sole requester's tenure expires, it is re-granted immediately. This is the wrap search returning to it last.
- tcnt:
  - Width 8 bits.
  - Cleared on every new grant, including a re-grant to the same channel.
  - Increments each cycle the grant is held.
- Outputs:
  - gnt, gnt_idx and gnt_valid come directly from registered state and stay mutually consistent at all times.
  - gnt == 32'b1 << gnt_idx when gnt_valid is high.
- Datapath: out_data ← in_data[gnt_idx] and out_valid ← gnt_valid, both registered every cycle.
  - While out_valid is low, out_data holds its last value.
- req bits other than the owner's may change freely during a grant. They affect only the next arbitration.

## Timing
- Reset: asserting rst_n immediately forces the following, regardless of the clock:
  - state = IDLE, ptr = 0, tcnt = 0;
  - gnt = 0, gnt_idx = 0, gnt_valid = 0;
  - out_data = 0, out_valid = 0.
- Release of reset takes effect at the first rising clk edge with rst_n high.
- Grant latency: req rises in cycle c → gnt is valid in cycle c+1.
- Release latency: owner's req falls in cycle c → gnt moves or clears in cycle c+1.
- Handover is back-to-back: the old grant is high in cycle c and the new grant is high in cycle c+1.
- Tenure bound: with the limit enabled, gnt stays on one channel for at most HOLD_MAX consecutive cycles before an arbitration point.
- Data latency: out_data and out_valid lag gnt_idx and gnt_valid by exactly 1 cycle.
- Reset asserted mid-grant: all outputs clear at once. The first grant after reset uses ptr = 0.

## Configuration
- ARB_TENURE_LIMIT_EN defined:
  - The tcnt counter and the tenure-expiry release are built.
  - A continuously requesting channel yields after HOLD_MAX cycles.
- Not defined:
  - No counter; HOLD_MAX is ignored.
  - A grant is held until the owner drops req.
  - The round-robin pointer behaviour is unchanged.

## Test plan
- Reset: hold rst_n low with req = 32'hFFFF_FFFF → gnt = 0, gnt_idx = 0, gnt_valid = 0, out_valid = 0. Release → gnt = 32'h1 one cycle later.
- Single requester: req = bit 5 in cycle c, in_data[5] = 20'hABCDE.
  - Cycle c+1: gnt_idx = 5.
  - Cycle c+2: out_data = 20'hABCDE, out_valid = 1.
  - Drop req → gnt = 0 next cycle.
- Rotation: bits 3, 7 and 20 requesting; each owner drops req after 2 cycles of grant → grant order 3, 7, 20, 3 with no idle cycles between grants.
- Tenure (macro defined, HOLD_MAX = 4): req bits 1 and 2 held high → grant sequence 1,1,1,1,2,2,2,2,1…
  - Repeat with only bit 1 held high → re-granted to 1 every 4 cycles.
  - Without the macro → grant stays on 1 indefinitely.
- Wrap-around: owner 31 releases while bit 0 and bit 30 are requesting → next gnt_idx = 0, then 30.
- Reset mid-grant: assert rst_n low while gnt_idx = 12 → outputs clear without a clock edge. After release with req = bits 12 and 4, first gnt_idx = 4.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin grant sequencer for the 32x20-bit select path.
// Define ARB_TENURE_LIMIT_EN to build the HOLD_MAX tenure limit.
module bus_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      req,
    input  logic [31:0][19:0] in_data,
    output logic [31:0]      gnt,
    output logic [4:0]       gnt_idx,
    output logic             gnt_valid,
    output logic [19:0]      out_data,
    output logic             out_valid
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    if (HOLD_MAX < 2 || HOLD_MAX > 256) begin : g_bad_hold
        $error("HOLD_MAX out of range 2..256");
    end

    logic [0:0] state;
    logic [4:0] ptr;
    logic [4:0] base;
    logic [4:0] win;
    logic       any_req;
    logic       expire;
    logic       rel;
    logic       arb;

    assign any_req = |req;
    assign base    = (state == GRANT) ? gnt_idx + 5'd1 : ptr;

    // First set request at or above base, wrapping 31 -> 0.
    always_comb begin
        logic found;
        logic [4:0] idx;
        win   = 5'd0;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            idx = base + 5'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

`ifdef ARB_TENURE_LIMIT_EN
    logic [7:0] tcnt;

    assign expire = (tcnt == 8'(HOLD_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= 8'd0;
        end else if (arb) begin
            tcnt <= 8'd0;
        end else if (state == GRANT) begin
            tcnt <= tcnt + 8'd1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    assign rel = (state == GRANT) && (!req[gnt_idx] || expire);
    assign arb = (state == IDLE) || rel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 5'd0;
            gnt       <= 32'd0;
            gnt_idx   <= 5'd0;
            gnt_valid <= 1'b0;
        end else if (arb) begin
            if (state == GRANT) begin
                ptr <= base;
            end
            if (any_req) begin
                state     <= GRANT;
                gnt       <= 32'h1 << win;
                gnt_idx   <= win;
                gnt_valid <= 1'b1;
            end else begin
                state     <= IDLE;
                gnt       <= 32'd0;
                gnt_idx   <= 5'd0;
                gnt_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= 20'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= gnt_valid;
            if (gnt_valid) begin
                out_data <= in_data[gnt_idx];
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of grant order, latency, tenure and reset.
// Output words are scoreboarded one cycle behind each expected grant.
module tb_bus_arbiter;

    logic              clk;
    logic              rst_n;
    logic [31:0]       req;
    logic [31:0][19:0] in_data;
    logic [31:0]       gnt;
    logic [4:0]        gnt_idx;
    logic              gnt_valid;
    logic [19:0]       out_data;
    logic              out_valid;

    int vectors;
    int miscompares;

    typedef struct {
        logic        v;
        logic [19:0] d;
    } exp_t;
    exp_t sb[$];

    bus_arbiter #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_data   (in_data),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_now(input string tag);
        cmp({tag, ".gnt"}, gnt, 32'd0);
        cmp({tag, ".idx"}, 32'(gnt_idx), 32'd0);
        cmp({tag, ".gv"}, 32'(gnt_valid), 32'd0);
        cmp({tag, ".ov"}, 32'(out_valid), 32'd0);
        cmp({tag, ".od"}, 32'(out_data), 32'd0);
    endtask

    // One clock; check grant now, check previous cycle's word, queue this one.
    task automatic cyc(input string tag, input logic v, input int idx);
        exp_t e;
        logic [31:0] eg;
        tick();
        eg = v ? (32'h1 << idx) : 32'd0;
        cmp({tag, ".gnt"}, gnt, eg);
        cmp({tag, ".idx"}, 32'(gnt_idx), v ? 32'(idx) : 32'd0);
        cmp({tag, ".gv"}, 32'(gnt_valid), 32'(v));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({tag, ".ov"}, 32'(out_valid), 32'(e.v));
            if (e.v) cmp({tag, ".od"}, 32'(out_data), 32'(e.d));
        end
        e.v = v;
        e.d = in_data[idx[4:0]];
        sb.push_back(e);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req         = 32'd0;
        for (int i = 0; i < 32; i++) begin
            in_data[i] = 20'h40000 + 20'(i * 20'h0111);
        end
        in_data[5] = 20'hABCDE;
        #2;
        req = 32'hFFFF_FFFF;
        repeat (3) tick();
        chk_idle_now("reset");
        rst_n = 1'b1;
        cyc("rst_rel", 1'b1, 0);
        req = 32'd0;
        cyc("rst_drop", 1'b0, 0);

        req = 32'h1 << 5;
        cyc("single", 1'b1, 5);
        cyc("single_hold", 1'b1, 5);
        req = 32'd0;
        cyc("single_drop", 1'b0, 0);
        cyc("single_idle", 1'b0, 0);

        pulse_reset();
        req = (32'h1 << 3) | (32'h1 << 7) | (32'h1 << 20);
        cyc("rot3a", 1'b1, 3);
        cyc("rot3b", 1'b1, 3);
        req = (32'h1 << 7) | (32'h1 << 20);
        cyc("rot7a", 1'b1, 7);
        cyc("rot7b", 1'b1, 7);
        req = (32'h1 << 20) | (32'h1 << 3);
        cyc("rot20a", 1'b1, 20);
        cyc("rot20b", 1'b1, 20);
        req = (32'h1 << 3) | (32'h1 << 7);
        cyc("rot3c", 1'b1, 3);
        req = 32'd0;
        cyc("rot_end", 1'b0, 0);

        req = 32'h1 << 31;
        cyc("wrap31a", 1'b1, 31);
        req = (32'h1 << 31) | 32'h1 | (32'h1 << 30);
        cyc("wrap31b", 1'b1, 31);
        req = 32'h1 | (32'h1 << 30);
        cyc("wrap0", 1'b1, 0);
        req = 32'h1 << 30;
        cyc("wrap30", 1'b1, 30);
        req = 32'd0;
        cyc("wrap_end", 1'b0, 0);

        pulse_reset();
        req = 32'h6;
`ifdef ARB_TENURE_LIMIT_EN
        for (int k = 0; k < 9; k++) begin
            cyc("tenure12", 1'b1, ((k / 4) % 2 == 0) ? 1 : 2);
        end
`else
        for (int k = 0; k < 9; k++) begin
            cyc("hold1", 1'b1, 1);
        end
`endif
        req = 32'd0;
        cyc("ten_idle", 1'b0, 0);
        req = 32'h2;
        for (int k = 0; k < 12; k++) begin
            cyc("sole1", 1'b1, 1);
        end
        req = 32'd0;
        cyc("sole_end", 1'b0, 0);

        req = 32'h1 << 12;
        cyc("mid12a", 1'b1, 12);
        cyc("mid12b", 1'b1, 12);
        rst_n = 1'b0;
        #1;
        chk_idle_now("mid_reset");
        req = (32'h1 << 12) | (32'h1 << 4);
        rst_n = 1'b1;
        sb.delete();
        cyc("post_rst4", 1'b1, 4);
        req = 32'd0;
        cyc("final", 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
